decode_parse: RTL

- LZS token parser sitting directly downstream of the 13-bit bit-window input stage of the decompressor.
- Inspects the MSB-first window, decodes literal / compressed-string / end-marker tokens, and returns the consumed bit count (stream_width, stream_ack).
- Emits one registered command per literal or copy segment to the history/window stage over a valid/ready handshake.

---
 rtl/decode_pkg.sv | 24 ++
 rtl/decode_parse_len.sv | 34 +++
 rtl/decode_parse.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/decode_pkg.sv
// Shared types and constants for the LZS token parser.
package decode_pkg;

    typedef enum logic [1:0] {ST_TOKEN, ST_LEN, ST_EXT, ST_DONE} state_t;

    localparam int unsigned LIT_BITS  = 9;
    localparam int unsigned SOFF_BITS = 9;
    localparam int unsigned LOFF_BITS = 13;
    localparam int unsigned NIB_BITS  = 4;
    localparam int unsigned EXT_BASE  = 8;
    localparam int unsigned EXT_STEP  = 15;

    localparam int unsigned CMD_OFF_W = 11;
    localparam int unsigned CMD_LEN_W = 5;

    typedef struct packed {
        logic                 literal;
        logic [7:0]           data;
        logic [CMD_OFF_W-1:0] offset;
        logic [CMD_LEN_W-1:0] length;
        logic                 last;
    } cmd_t;

endpackage

// File: rtl/decode_parse_len.sv
// Combinational LZS length-code decoder; code is the top 4 bits of the window.
module decode_parse_len
    import decode_pkg::*;
(
    input  logic [3:0]           code,
    output logic [CMD_LEN_W-1:0] length,
    output logic [3:0]           width,
    output logic                 to_ext
);

    always_comb begin
        length = '0;
        width  = 4'd2;
        to_ext = 1'b0;
        case (code[3:2])
            2'b00: length = 5'd2;
            2'b01: length = 5'd3;
            2'b10: length = 5'd4;
            default: begin
                width = 4'(NIB_BITS);
                case (code[1:0])
                    2'b00: length = 5'd5;
                    2'b01: length = 5'd6;
                    2'b10: length = 5'd7;
                    default: begin
                        length = 5'(EXT_BASE);
                        to_ext = 1'b1;
                    end
                endcase
            end
        endcase
    end

endmodule

// File: rtl/decode_parse.sv
// LZS token parser: decodes literal / copy / end-marker tokens from a 13-bit
// MSB-first window and emits one registered command per literal or copy segment.
module decode_parse
    import decode_pkg::*;
#(
    parameter int LEN_W = 5,
    parameter int OFF_W = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [12:0]      stream_data,
    input  logic             stream_valid,
    input  logic             stream_done,
    output logic [3:0]       stream_width,
    output logic             stream_ack,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_literal,
    output logic [7:0]       out_data,
    output logic [OFF_W-1:0] out_offset,
    output logic [LEN_W-1:0] out_length,
    output logic             out_last,
    output logic             parse_err
);

    localparam logic [3:0] W_LIT  = 4'(LIT_BITS);
    localparam logic [3:0] W_SOFF = 4'(SOFF_BITS);
    localparam logic [3:0] W_LOFF = 4'(LOFF_BITS);
    localparam logic [3:0] W_NIB  = 4'(NIB_BITS);
    localparam logic [3:0] NIB_EXT = 4'(EXT_STEP);

    state_t                state, state_n;
    logic [CMD_LEN_W-1:0]  acc, acc_n;
    logic [CMD_OFF_W-1:0]  off_q, off_n;
    cmd_t                  cmd_q, new_cmd;
    logic                  slot_free, active;
    logic                  emit, marker, err;
    logic [3:0]            width;
    logic [CMD_LEN_W-1:0]  len_dec, ext_sum;
    logic [3:0]            len_w;
    logic                  len_to_ext;
    logic [3:0]            nib;

    decode_parse_len u_len (
        .code   (stream_data[12:9]),
        .length (len_dec),
        .width  (len_w),
        .to_ext (len_to_ext)
    );

    assign slot_free = ~out_valid | out_ready;
    assign active    = stream_valid & slot_free & (state != ST_DONE);
    assign nib       = stream_data[12:9];
    assign ext_sum   = acc + CMD_LEN_W'(nib);

    always_comb begin
        state_n = state;
        acc_n   = acc;
        off_n   = off_q;
        width   = '0;
        emit    = 1'b0;
        marker  = 1'b0;
        err     = 1'b0;
        new_cmd = '0;
        case (state)
            ST_TOKEN: begin
                if (active) begin
                    if (!stream_data[12]) begin
                        width           = W_LIT;
                        emit            = 1'b1;
                        new_cmd.literal = 1'b1;
                        new_cmd.data    = stream_data[11:4];
                    end else if (stream_data[11]) begin
                        width = W_SOFF;
                        if (stream_data[10:4] != '0) begin
                            off_n   = {4'b0, stream_data[10:4]};
                            state_n = ST_LEN;
                        end else begin
                            marker  = 1'b1;
                            state_n = ST_DONE;
                        end
                    end else begin
                        width = W_LOFF;
                        if (stream_data[10:0] == '0) begin
                            err     = 1'b1;
                            state_n = ST_DONE;
                        end else begin
                            off_n   = stream_data[10:0];
                            state_n = ST_LEN;
                        end
                    end
                end
            end
            ST_LEN: begin
                if (active) begin
                    width = len_w;
                    if (len_to_ext) begin
                        acc_n   = len_dec;
                        state_n = ST_EXT;
                    end else begin
                        emit           = 1'b1;
                        new_cmd.offset = off_q;
                        new_cmd.length = len_dec;
                        state_n        = ST_TOKEN;
                    end
                end else if (!stream_valid && stream_done) begin
                    err     = 1'b1;
                    state_n = ST_DONE;
                end
            end
            ST_EXT: begin
                if (active) begin
                    width          = W_NIB;
                    new_cmd.offset = off_q;
                    new_cmd.length = ext_sum;
                    acc_n          = '0;
                    emit           = (ext_sum != '0);
                    if (nib != NIB_EXT)
                        state_n = ST_TOKEN;
                end else if (!stream_valid && stream_done) begin
                    err     = 1'b1;
                    state_n = ST_DONE;
                end
            end
            default: begin
                if (start) begin
                    state_n = ST_TOKEN;
                    acc_n   = '0;
                end
            end
        endcase
        // An acked marker always finds the register free or draining this
        // cycle, so the last flag travels on its own zero-length command.
        if (marker)
            new_cmd.last = 1'b1;
    end

    assign stream_ack   = active;
    assign stream_width = width;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_TOKEN;
            acc       <= '0;
            off_q     <= '0;
            cmd_q     <= '0;
            out_valid <= 1'b0;
            parse_err <= 1'b0;
        end else begin
            state <= state_n;
            acc   <= acc_n;
            off_q <= off_n;
            if (err)
                parse_err <= 1'b1;
            else if (state == ST_DONE && start)
                parse_err <= 1'b0;
            if (emit || marker) begin
                cmd_q     <= new_cmd;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
                if (state != ST_DONE)
                    cmd_q.last <= 1'b0;
            end
            if (state == ST_DONE && start && slot_free)
                cmd_q.last <= 1'b0;
        end
    end

    assign out_literal = cmd_q.literal;
    assign out_data    = cmd_q.data;
    assign out_offset  = OFF_W'(cmd_q.offset);
    assign out_length  = LEN_W'(cmd_q.length);
    assign out_last    = cmd_q.last;

endmodule
